// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 SCPU.
// Generates the PC / IF/ID / ID/EX / EX/MEM / MEM/WB enables and bubble
// controls. A small scoreboard tracks in-flight destination registers so
// that load-use and RAW hazards can be detected. The controller also
// handles EX-stage redirects and freezes the pipe during data-memory waits.
module pipe_hazard_ctrl #(
  parameter int          FORWARD_EN = 1,
  parameter int unsigned MAX_WAIT   = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_IDEX,
  input  logic             rst_IDEX,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_regwrite,
  input  logic             id_is_load,
  input  logic             id_valid,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             PC_en,
  output logic             en_IFID,
  output logic             NOP_IFID,
  output logic             en_IDEX,
  output logic             NOP_IDEX,
  output logic             en_EXMEM,
  output logic             en_MEMWB,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             dmem_timeout
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       is_load;
  } slot_t;

  localparam logic [15:0] WAIT_LIM = 16'(MAX_WAIT);
  localparam logic [15:0] WAIT_PRE = 16'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  slot_t       ex_q, mem_q, wb_q;
  slot_t       id_slot;
  logic [15:0] wait_q;
  logic        mem_wait;
  logic        hit_ex, hit_mem;
  logic        data_hazard;

  // The WB slot never stalls (write-first register file); it is kept only
  // so the scoreboard mirrors the pipe.
  logic        unused_ok;
  assign unused_ok = ^{wb_q, mem_q.is_load};

  function automatic logic slot_hit(input slot_t s,
                                    input logic [4:0] rs1, input logic u1,
                                    input logic [4:0] rs2, input logic u2);
    return s.valid && s.regwrite && (s.rd != 5'd0) &&
           ((u1 && (rs1 == s.rd)) || (u2 && (rs2 == s.rd)));
  endfunction

  // Hazard detection against the in-flight EX and MEM writers.
  always_comb begin
    mem_wait    = dmem_req && !dmem_ack;
    hit_ex      = slot_hit(ex_q,  id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used);
    hit_mem     = slot_hit(mem_q, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used);
    data_hazard = (FORWARD_EN != 0) ? (hit_ex && ex_q.is_load) : (hit_ex || hit_mem);
    id_slot     = '{valid: 1'b1, rd: id_rd_addr, regwrite: id_regwrite, is_load: id_is_load};
  end

  // Next state and prioritised pipe controls: reset, freeze, redirect, hazard.
  always_comb begin
    state_d  = state_q;
    PC_en    = 1'b1;
    en_IFID  = 1'b1;
    NOP_IFID = 1'b0;
    en_IDEX  = 1'b1;
    NOP_IDEX = 1'b0;
    en_EXMEM = 1'b1;
    en_MEMWB = 1'b1;
    case (state_q)
      RUN:      if (mem_wait) state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ack) state_d = RUN;
      default:  state_d = RUN;
    endcase
    if (rst_IDEX) begin
      state_d  = RUN;
      PC_en    = 1'b0;
      en_IFID  = 1'b0;
      NOP_IFID = 1'b1;
      en_IDEX  = 1'b0;
      NOP_IDEX = 1'b1;
      en_EXMEM = 1'b0;
      en_MEMWB = 1'b0;
    end else if (mem_wait) begin
      PC_en    = 1'b0;
      en_IFID  = 1'b0;
      en_IDEX  = 1'b0;
      en_EXMEM = 1'b0;
      en_MEMWB = 1'b0;
    end else if (ex_redirect) begin
      NOP_IFID = 1'b1;
      NOP_IDEX = 1'b1;
    end else if (data_hazard) begin
      PC_en    = 1'b0;
      en_IFID  = 1'b0;
      NOP_IDEX = 1'b1;
    end
  end

  // State, scoreboard shift, wait/timeout tracking and stall counter.
  always_ff @(posedge clk_IDEX or posedge rst_IDEX) begin
    if (rst_IDEX) begin
      state_q      <= RUN;
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      wait_q       <= '0;
      dmem_timeout <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      state_q <= state_d;
      if (en_IDEX)  ex_q  <= (NOP_IDEX || !id_valid) ? '0 : id_slot;
      if (en_EXMEM) mem_q <= ex_q;
      if (en_MEMWB) wb_q  <= mem_q;
      if (dmem_ack) begin
        wait_q <= '0;
      end else if (mem_wait) begin
        if (wait_q != WAIT_LIM) wait_q <= wait_q + 16'd1;
        if (wait_q == WAIT_PRE) dmem_timeout <= 1'b1;
      end
      if (!PC_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with forwarding and one
// without, both with MAX_WAIT=2, driven by the same ID/EX/MEM stimulus.
module tb_pipe_hazard_ctrl;

  logic        clk_IDEX = 1'b0;
  logic        rst_IDEX;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_rs1_used, id_rs2_used, id_regwrite, id_is_load, id_valid;
  logic        ex_redirect, dmem_req, dmem_ack;

  logic        f_PC_en, f_en_IFID, f_NOP_IFID, f_en_IDEX, f_NOP_IDEX, f_en_EXMEM, f_en_MEMWB;
  logic        n_PC_en, n_en_IFID, n_NOP_IFID, n_en_IDEX, n_NOP_IDEX, n_en_EXMEM, n_en_MEMWB;
  logic [15:0] f_cnt, n_cnt;
  logic        f_tmo, n_tmo;
  logic [6:0]  f_vec, n_vec;

  int errors = 0;
  int checks = 0;

  // {PC_en, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, en_EXMEM, en_MEMWB}
  localparam logic [6:0] V_RUN   = 7'b1101011;
  localparam logic [6:0] V_STALL = 7'b0001111;
  localparam logic [6:0] V_REDIR = 7'b1111111;
  localparam logic [6:0] V_FRZ   = 7'b0000000;
  localparam logic [6:0] V_RST   = 7'b0010100;

  assign f_vec = {f_PC_en, f_en_IFID, f_NOP_IFID, f_en_IDEX, f_NOP_IDEX, f_en_EXMEM, f_en_MEMWB};
  assign n_vec = {n_PC_en, n_en_IFID, n_NOP_IFID, n_en_IDEX, n_NOP_IDEX, n_en_EXMEM, n_en_MEMWB};

  always #5 clk_IDEX = ~clk_IDEX;

  pipe_hazard_ctrl #(.FORWARD_EN(1), .MAX_WAIT(2), .CNT_W(16)) u_fwd (
    .clk_IDEX(clk_IDEX), .rst_IDEX(rst_IDEX),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .id_valid(id_valid), .ex_redirect(ex_redirect),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .PC_en(f_PC_en), .en_IFID(f_en_IFID), .NOP_IFID(f_NOP_IFID),
    .en_IDEX(f_en_IDEX), .NOP_IDEX(f_NOP_IDEX),
    .en_EXMEM(f_en_EXMEM), .en_MEMWB(f_en_MEMWB),
    .stall_cnt(f_cnt), .dmem_timeout(f_tmo)
  );

  pipe_hazard_ctrl #(.FORWARD_EN(0), .MAX_WAIT(2), .CNT_W(16)) u_nof (
    .clk_IDEX(clk_IDEX), .rst_IDEX(rst_IDEX),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .id_valid(id_valid), .ex_redirect(ex_redirect),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .PC_en(n_PC_en), .en_IFID(n_en_IFID), .NOP_IFID(n_NOP_IFID),
    .en_IDEX(n_en_IDEX), .NOP_IDEX(n_NOP_IDEX),
    .en_EXMEM(n_en_EXMEM), .en_MEMWB(n_en_MEMWB),
    .stall_cnt(n_cnt), .dmem_timeout(n_tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [6:0] ef, input logic [6:0] en);
    #1;
    chk({tag, "_fwd"}, 32'(f_vec), 32'(ef));
    chk({tag, "_nof"}, 32'(n_vec), 32'(en));
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] ef, input logic [15:0] en);
    chk({tag, "_cnt_fwd"}, 32'(f_cnt), 32'(ef));
    chk({tag, "_cnt_nof"}, 32'(n_cnt), 32'(en));
  endtask

  task automatic chk_tmo(input string tag, input logic e);
    chk({tag, "_tmo_fwd"}, 32'(f_tmo), 32'(e));
    chk({tag, "_tmo_nof"}, 32'(n_tmo), 32'(e));
  endtask

  task automatic tick();
    @(posedge clk_IDEX);
    #1;
  endtask

  task automatic idle();
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_regwrite = 1'b0; id_is_load = 1'b0; id_valid = 1'b0;
    ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic ld);
    id_rs1_addr = rs1; id_rs1_used = u1;
    id_rs2_addr = rs2; id_rs2_used = u2;
    id_rd_addr  = rd;  id_regwrite = rw; id_is_load = ld;
    id_valid    = 1'b1;
  endtask

  task automatic flush();
    idle();
    chk_vec("flush", V_RUN, V_RUN);
    tick(); tick(); tick();
  endtask

  initial begin
    rst_IDEX = 1'b1;
    idle();
    chk_vec("reset", V_RST, V_RST);
    chk_cnt("reset", 16'd0, 16'd0);
    chk_tmo("reset", 1'b0);
    tick(); tick();
    rst_IDEX = 1'b0;
    chk_vec("post_reset", V_RUN, V_RUN);
    tick();

    // Load-use on x5
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    chk_vec("lu_issue", V_RUN, V_RUN);
    tick();
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk_vec("lu_c1", V_STALL, V_STALL);
    tick();
    chk_vec("lu_c2", V_RUN, V_STALL);
    chk_cnt("lu_c2", 16'd1, 16'd1);
    tick();
    chk_vec("lu_c3", V_RUN, V_RUN);
    chk_cnt("lu_c3", 16'd1, 16'd2);
    tick();
    flush();

    // ALU writer x7, reader on rs2
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    chk_vec("alu_issue", V_RUN, V_RUN);
    tick();
    set_id(5'd3, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
    chk_vec("alu_c1", V_RUN, V_STALL);
    tick();
    chk_vec("alu_c2", V_RUN, V_STALL);
    tick();
    chk_vec("alu_c3", V_RUN, V_RUN);
    chk_cnt("alu_c3", 16'd1, 16'd4);
    tick();
    flush();

    // x0 writer never hazards
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    chk_vec("x0_issue", V_RUN, V_RUN);
    tick();
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    chk_vec("x0_c1", V_RUN, V_RUN);
    tick();
    chk_vec("x0_c2", V_RUN, V_RUN);
    tick();
    flush();

    // Redirect coinciding with a load-use hit on x9
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    chk_vec("rd_issue", V_RUN, V_RUN);
    tick();
    set_id(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex_redirect = 1'b1;
    chk_vec("rd_redir", V_REDIR, V_REDIR);
    chk_cnt("rd_redir", 16'd1, 16'd4);
    tick();
    ex_redirect = 1'b0;
    chk_vec("rd_after", V_RUN, V_STALL);
    tick();
    chk_vec("rd_after2", V_RUN, V_RUN);
    chk_cnt("rd_after2", 16'd1, 16'd5);
    tick();
    flush();

    // Data-memory wait of 3 cycles with a pending load-use behind it
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    chk_vec("mw_issue", V_RUN, V_RUN);
    tick();
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    dmem_req = 1'b1;
    chk_vec("mw_f1", V_FRZ, V_FRZ);
    tick();
    chk_vec("mw_f2", V_FRZ, V_FRZ);
    chk_tmo("mw_f2", 1'b0);
    tick();
    chk_vec("mw_f3", V_FRZ, V_FRZ);
    tick();
    dmem_ack = 1'b1;
    chk_vec("mw_ack", V_STALL, V_STALL);
    chk_tmo("mw_ack", 1'b1);
    chk_cnt("mw_ack", 16'd4, 16'd8);
    tick();
    dmem_req = 1'b0; dmem_ack = 1'b0;
    chk_vec("mw_post", V_RUN, V_STALL);
    chk_tmo("mw_post", 1'b1);
    chk_cnt("mw_post", 16'd5, 16'd9);
    tick();
    chk_vec("mw_post2", V_RUN, V_RUN);
    chk_cnt("mw_post2", 16'd5, 16'd10);
    tick();
    flush();

    // Reset asserted while waiting on memory with a load in EX
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    chk_vec("rw_issue", V_RUN, V_RUN);
    tick();
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    dmem_req = 1'b1;
    chk_vec("rw_frz", V_FRZ, V_FRZ);
    tick();
    rst_IDEX = 1'b1;
    chk_vec("rw_rst", V_RST, V_RST);
    chk_cnt("rw_rst", 16'd0, 16'd0);
    chk_tmo("rw_rst", 1'b0);
    tick();
    rst_IDEX = 1'b0;
    dmem_req = 1'b0;
    chk_vec("rw_rel", V_RUN, V_RUN);
    chk_cnt("rw_rel", 16'd0, 16'd0);
    chk_tmo("rw_rel", 1'b0);
    tick();
    chk_cnt("rw_rel2", 16'd0, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
